uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side buffer directly downstream of the UART receiver. Captures each
//  received byte and its error flag on the receiver's ready pulse, and stores them
//  in a show-ahead FIFO for the host/bus side. Generates the RTS flow-control level
//  fed back to the receiver's rts input, with hysteresis. Tracks overflow and
//  error-only receptions (no ready pulse).
// PARAMETERS
//  DEPTH      16  FIFO entries; power of two
//  ADDR_W     4   log2(DEPTH)
//  RTS_HIGH   12  count at or above which RTS drops (handshake on)
//  RTS_LOW    8   count at or below which RTS returns; RTS_LOW < RTS_HIGH <= DEPTH
// PORTS
//  clk        in   1         system clock, rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  handshake  in   1         1 = RTS flow control enabled
//  rx_data    in   8         byte from receiver
//  rx_ready   in   1         receiver byte-complete strobe (level, >=1 cycle)
//  rx_error   in   1         receiver error flag (may stay high)
//  rd_en      in   1         pop request from consumer
//  rd_data    out  8         head byte (valid when !empty)
//  rd_err     out  1         error flag stored with head byte
//  empty      out  1         FIFO empty
//  full       out  1         FIFO full
//  count      out  ADDR_W+1  entries held, 0..DEPTH
//  rts        out  1         1 = receiver may accept data
//  overflow   out  1         sticky: push dropped because FIFO full
//  clear_ovf  in   1         synchronous clear of overflow
//  err_count  out  8         saturating count of error-only events
// BEHAVIOUR
//  Reset (rst_n=0, async): pointers/count=0, empty=1, full=0, rd_data=0, rd_err=0,
//   rts=1, overflow=0, err_count=0, edge-detect registers=0, RTS FSM = RTS_ON.
//  Push: on rx_ready rising edge (rx_ready=1, registered prev=0), write {rx_error,rx_data}
//   sampled that cycle. A multi-cycle ready pulse pushes once only.
//  Latency: push sampled at edge N -> empty=0, count+1, rd_data valid after edge N.
//  Pop: rd_en=1 and !empty at edge N -> head advances and count-1 after edge N.
//   rd_en while empty is ignored; no state change.
//  Show-ahead: rd_data/rd_err continuously reflect the head entry. When empty they
//   hold the last value.
//  Simultaneous push+pop: both take effect and count is unchanged. This is legal when
//   full; the pop frees the slot, so no overflow occurs.
//  Push while full with no pop: data dropped; overflow=1 at the next edge.
//   overflow stays set until clear_ovf=1. If clear_ovf and a new overflow occur in the
//   same cycle, overflow stays 1.
//  Pointers: ADDR_W bits, wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0).
//  Error-only event: rx_error rising edge while rx_ready=0 -> err_count+1, saturating
//   at 255, no push. An error rising together with a ready edge is stored via rd_err
//   and is not counted.
//  RTS FSM, registered, evaluated on next-state count:
//   RTS_ON  (rts=1): -> RTS_OFF when handshake=1 and count >= RTS_HIGH.
//   RTS_OFF (rts=0): -> RTS_ON  when count <= RTS_LOW or handshake=0.
//   With handshake=0 the FSM stays in RTS_ON and rts=1.
//  Reset mid-operation: all contents discarded immediately, independent of clk.
// TESTING
//  1 Reset, then ready pulses with 0x55, 0xA3 (error=0) -> count=2, rd_data=0x55;
//    rd_en for 1 cycle -> rd_data=0xA3, count=1.
//  2 Hold rx_ready high 5 cycles with 0x11 -> exactly one entry (count=1).
//  3 Push 17 bytes into DEPTH=16 with no pops -> full=1, count=16, overflow=1, head is
//    the first byte; clear_ovf -> overflow=0.
//  4 Full FIFO, push+rd_en in same cycle -> count stays 16, overflow stays 0, new byte
//    at tail (visible after 16 pops).
//  5 handshake=1: push 12 -> rts=0 after edge that makes count 12; pop to 9 -> rts=0;
//    pop to 8 -> rts=1. Set handshake=0 at count 12 -> rts=1 next cycle.
//  6 Three rx_error rising edges without ready -> err_count=3; ready with error=1 and
//    0x7E -> rd_err=1, err_count stays 3. Assert rst_n=0 mid-burst -> all outputs
//    reach reset values without a clock edge.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer for a UART receiver.
// Each received byte is captured with its error flag on the rising edge of
// the receiver's ready strobe and stored in a show-ahead FIFO.
// The block also drives the RTS flow-control level back to the receiver,
// with hysteresis, and tracks overflow and error-only receptions.
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int RTS_HIGH = 12,
  parameter int RTS_LOW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              handshake,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              rx_error,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rd_err,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              rts,
  output logic              overflow,
  input  logic              clear_ovf,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   HIGH_CNT = (ADDR_W + 1)'(RTS_HIGH);
  localparam logic [ADDR_W:0]   LOW_CNT  = (ADDR_W + 1)'(RTS_LOW);
  localparam logic [ADDR_W:0]   ZERO_CNT = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ONE_PTR  = ADDR_W'(1);

  typedef enum logic [0:0] {
    RTS_ON  = 1'b0,
    RTS_OFF = 1'b1
  } rts_state_e;

  // Storage and pointers
  logic [8:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;

  // Strobe edge detection
  logic              rdy_prev_q, rdy_prev_d;
  logic              err_prev_q, err_prev_d;

  // Registered outputs
  logic [8:0]        head_q, head_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        err_count_q, err_count_d;
  rts_state_e        rts_state_q;
  logic              rts_q;

  // Per-cycle events
  logic [8:0]        wr_word;
  logic              push;
  logic              pop;
  logic              wr_ok;
  logic              ovf_set;
  logic              err_evt;

  // Decode push/pop/error events from the strobes and the current occupancy
  always_comb begin
    wr_word = {rx_error, rx_data};
    push    = rx_ready & ~rdy_prev_q;
    pop     = rd_en & ~empty_q;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept
    wr_ok   = push & (~full_q | pop);
    ovf_set = push & full_q & ~pop;
    // An error edge that coincides with ready is stored with the byte instead
    err_evt = rx_error & ~err_prev_q & ~rx_ready;
  end

  // Next-state for pointers, occupancy and edge-detect history
  always_comb begin
    rdy_prev_d = rx_ready;
    err_prev_d = rx_error;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + ONE_PTR;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + ONE_PTR;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_ok, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase

    empty_d = (count_d == ZERO_CNT);
    full_d  = (count_d == FULL_CNT);
  end

  // Next head entry; when the FIFO drains the last head value is held
  always_comb begin
    if (count_d == ZERO_CNT) begin
      head_d = head_q;
    end else if (wr_ok && (wr_ptr_q == rd_ptr_d)) begin
      // The slot being written this cycle becomes the head: bypass the array
      head_d = wr_word;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Sticky overflow and saturating error-only counter
  always_comb begin
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    if (err_evt && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // FIFO storage array; contents are only read once written, so no reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= {ADDR_W{1'b0}};
      rd_ptr_q    <= {ADDR_W{1'b0}};
      count_q     <= ZERO_CNT;
      rdy_prev_q  <= 1'b0;
      err_prev_q  <= 1'b0;
      head_q      <= 9'h000;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rdy_prev_q  <= rdy_prev_d;
      err_prev_q  <= err_prev_d;
      head_q      <= head_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      err_count_q <= err_count_d;
    end
  end

  // RTS hysteresis FSM, judged on the occupancy after this cycle's push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rts_state_q <= RTS_ON;
      rts_q       <= 1'b1;
    end else begin
      case (rts_state_q)
        RTS_ON: begin
          if (handshake && (count_d >= HIGH_CNT)) begin
            rts_state_q <= RTS_OFF;
            rts_q       <= 1'b0;
          end else begin
            rts_state_q <= RTS_ON;
            rts_q       <= 1'b1;
          end
        end
        RTS_OFF: begin
          if (!handshake || (count_d <= LOW_CNT)) begin
            rts_state_q <= RTS_ON;
            rts_q       <= 1'b1;
          end else begin
            rts_state_q <= RTS_OFF;
            rts_q       <= 1'b0;
          end
        end
        default: begin
          rts_state_q <= RTS_ON;
          rts_q       <= 1'b1;
        end
      endcase
    end
  end

  assign rd_data   = head_q[7:0];
  assign rd_err    = head_q[8];
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign rts       = rts_q;
  assign overflow  = overflow_q;
  assign err_count = err_count_q;

endmodule
